// File: rtl/sram_ifc_param_if.sv
// Signal bundle between the fabric, the sram_ifc_param block and the dual-port OpenRAM macro.
// Read results: d_fabric_out is meaningful only in a cycle where d_fabric_out_valid is high; there is no back-pressure.
interface sram_ifc_param_if #(
  parameter int DATA_W = 32,
  parameter int SUB_W  = 8,
  parameter int ADDR_W = 8,
  parameter int CONF_W = 2
);
  localparam int NSUB   = DATA_W / SUB_W;
  localparam int SUBA_W = $clog2(NSUB);
  localparam int FA_W   = ADDR_W + SUBA_W;

  logic [DATA_W-1:0] d_fabric_in;
  logic              csb;
  logic              web;
  logic              reb;
  logic [FA_W-1:0]   addr_w;
  logic [FA_W-1:0]   addr_r;
  logic [CONF_W-1:0] conf;
  logic              out_reg;
  logic [DATA_W-1:0] d_sram_in;
  logic [NSUB-1:0]   w_mask;
  logic [DATA_W-1:0] d_sram_out;
  logic              csb0_sync;
  logic              web0_sync;
  logic              csb1_sync;
  logic [ADDR_W-1:0] baseaddr_w_sync;
  logic [ADDR_W-1:0] baseaddr_r_sync;
  logic [DATA_W-1:0] d_fabric_out;
  logic              d_fabric_out_valid;

  modport slave (
    input  d_fabric_in, csb, web, reb, addr_w, addr_r, conf, out_reg, d_sram_out,
    output d_sram_in, w_mask, csb0_sync, web0_sync, csb1_sync,
           baseaddr_w_sync, baseaddr_r_sync, d_fabric_out, d_fabric_out_valid
  );

  modport master (
    output d_fabric_in, csb, web, reb, addr_w, addr_r, conf, out_reg, d_sram_out,
    input  d_sram_in, w_mask, csb0_sync, web0_sync, csb1_sync,
           baseaddr_w_sync, baseaddr_r_sync, d_fabric_out, d_fabric_out_valid
  );
endinterface

// File: rtl/sram_ifc_param.sv
// Parametrised fabric-to-SRAM interface: lane-masked writes, aligned narrow reads,
// same-row write forwarding and an optional registered output stage.
module sram_ifc_param #(
  parameter int DATA_W = 32,
  parameter int SUB_W  = 8,
  parameter int ADDR_W = 8,
  parameter int CONF_W = 2
) (
  input logic          clk,
  input logic          rst,
  sram_ifc_param_if.slave bus
);
  localparam int NSUB   = DATA_W / SUB_W;
  localparam int SUBA_W = $clog2(NSUB);
  localparam int FA_W   = ADDR_W + SUBA_W;

  // Element size exponent; conf values beyond the lane count mean a full word.
  function automatic int lane_exp(input logic [CONF_W-1:0] c);
    return (int'(c) > SUBA_W) ? SUBA_W : int'(c);
  endfunction

  logic [DATA_W-1:0] s1_data;
  logic [FA_W-1:0]   s1_addr_w, s1_addr_r;
  logic [CONF_W-1:0] s1_conf;
  logic              s1_csb0, s1_web0, s1_csb1, s1_rd_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_data   <= '0;
      s1_addr_w <= '0;
      s1_addr_r <= '0;
      s1_conf   <= '0;
      s1_csb0   <= 1'b1;
      s1_web0   <= 1'b1;
      s1_csb1   <= 1'b1;
      s1_rd_v   <= 1'b0;
    end else begin
      s1_data   <= bus.d_fabric_in;
      s1_addr_w <= bus.addr_w;
      s1_addr_r <= bus.addr_r;
      s1_conf   <= bus.conf;
      s1_csb0   <= bus.csb | bus.web;
      s1_web0   <= bus.web;
      s1_csb1   <= bus.csb | bus.reb;
      s1_rd_v   <= ~(bus.csb | bus.reb);
    end
  end

  logic [SUBA_W-1:0] sub_w, sub_r;
  logic [NSUB-1:0]   wmask_c;
  logic [DATA_W-1:0] wdata_c;
  logic              coll_c;

  assign sub_w = s1_addr_w[FA_W-1 -: SUBA_W];
  assign sub_r = s1_addr_r[FA_W-1 -: SUBA_W];

  // The element is replicated across the word so any selected lane carries its slice.
  always_comb begin
    int e;
    e       = lane_exp(s1_conf);
    wmask_c = '0;
    wdata_c = '0;
    for (int i = 0; i < NSUB; i++) begin
      wmask_c[i] = ~s1_csb0 & ((i >> e) == (int'(sub_w) >> e));
      wdata_c[i*SUB_W +: SUB_W] = s1_data[(i & ((1 << e) - 1))*SUB_W +: SUB_W];
    end
  end

  assign coll_c = ~s1_csb0 & ~s1_csb1 & (s1_addr_w[ADDR_W-1:0] == s1_addr_r[ADDR_W-1:0]);

  assign bus.d_sram_in       = wdata_c;
  assign bus.w_mask          = wmask_c;
  assign bus.csb0_sync       = s1_csb0;
  assign bus.web0_sync       = s1_web0;
  assign bus.csb1_sync       = s1_csb1;
  assign bus.baseaddr_w_sync = s1_addr_w[ADDR_W-1:0];
  assign bus.baseaddr_r_sync = s1_addr_r[ADDR_W-1:0];

  logic              s2_rd_v, s2_coll, s3_rd_v, s3_coll, out_v_q;
  logic [CONF_W-1:0] s2_conf, s3_conf;
  logic [SUBA_W-1:0] s2_sub_r, s3_sub_r;
  logic [DATA_W-1:0] s2_wdata, s3_wdata, s3_dout, out_q;
  logic [NSUB-1:0]   s2_wmask, s3_wmask;
  logic [DATA_W-1:0] merged_c, elem_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_rd_v  <= 1'b0;
      s2_coll  <= 1'b0;
      s2_conf  <= '0;
      s2_sub_r <= '0;
      s2_wdata <= '0;
      s2_wmask <= '0;
      s3_rd_v  <= 1'b0;
      s3_coll  <= 1'b0;
      s3_conf  <= '0;
      s3_sub_r <= '0;
      s3_wdata <= '0;
      s3_wmask <= '0;
      s3_dout  <= '0;
      out_q    <= '0;
      out_v_q  <= 1'b0;
    end else begin
      s2_rd_v  <= s1_rd_v;
      s2_coll  <= coll_c;
      s2_conf  <= s1_conf;
      s2_sub_r <= sub_r;
      s2_wdata <= wdata_c;
      s2_wmask <= wmask_c;
      s3_rd_v  <= s2_rd_v;
      s3_coll  <= s2_coll;
      s3_conf  <= s2_conf;
      s3_sub_r <= s2_sub_r;
      s3_wdata <= s2_wdata;
      s3_wmask <= s2_wmask;
      s3_dout  <= bus.d_sram_out;
      out_q    <= elem_c;
      out_v_q  <= s3_rd_v;
    end
  end

  // The SRAM returns the pre-write row on a same-cycle collision, so written lanes are patched in.
  always_comb begin
    int e, base;
    e        = lane_exp(s3_conf);
    base     = (int'(s3_sub_r) >> e) << e;
    merged_c = s3_dout;
    elem_c   = '0;
    for (int i = 0; i < NSUB; i++) begin
      if (s3_coll & s3_wmask[i]) merged_c[i*SUB_W +: SUB_W] = s3_wdata[i*SUB_W +: SUB_W];
    end
    for (int i = 0; i < NSUB; i++) begin
      if (i < (1 << e)) elem_c[i*SUB_W +: SUB_W] = merged_c[(base + i)*SUB_W +: SUB_W];
    end
  end

  assign bus.d_fabric_out       = bus.out_reg ? out_q   : elem_c;
  assign bus.d_fabric_out_valid = bus.out_reg ? out_v_q : s3_rd_v;
endmodule

// File: tb/tb_sram_ifc_param.sv
// Self-checking bench for sram_ifc_param: directed vectors plus a short mixed stream,
// with an SRAM behavioural model and a queue-based scoreboard.
module tb_sram_ifc_param;
  localparam int DATA_W = 32;
  localparam int SUB_W  = 8;
  localparam int ADDR_W = 8;
  localparam int CONF_W = 2;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   run = 0;
  int   max_run = 0;

  logic [DATA_W-1:0] exp_q[$];
  int                cyc_q[$];
  logic [DATA_W-1:0] ref_mem [256];
  logic [DATA_W-1:0] sram_mem [256];

  sram_ifc_param_if #(.DATA_W(DATA_W), .SUB_W(SUB_W), .ADDR_W(ADDR_W), .CONF_W(CONF_W)) bus ();

  sram_ifc_param #(.DATA_W(DATA_W), .SUB_W(SUB_W), .ADDR_W(ADDR_W), .CONF_W(CONF_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM macro: port 0 masked write, port 1 synchronous read returning the pre-write row
  always @(posedge clk) begin
    if (bus.csb0_sync === 1'b0)
      for (int i = 0; i < 4; i++)
        if (bus.w_mask[i]) sram_mem[bus.baseaddr_w_sync][i*8 +: 8] <= bus.d_sram_in[i*8 +: 8];
    if (bus.csb1_sync === 1'b0) bus.d_sram_out <= sram_mem[bus.baseaddr_r_sync];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int eff(input logic [1:0] c);
    return (c > 2'd2) ? 2 : int'(c);
  endfunction

  function automatic logic [31:0] emask(input int e);
    int w;
    w = 8 << e;
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
  endfunction

  function automatic int estart(input logic [9:0] a, input int e);
    return ((int'(a[9:8]) >> e) << e) * 8;
  endfunction

  task automatic model_write(input logic [9:0] a, input logic [1:0] c, input logic [31:0] d);
    int e, st;
    logic [31:0] m;
    e  = eff(c);
    st = estart(a, e);
    m  = emask(e);
    ref_mem[a[7:0]] = (ref_mem[a[7:0]] & ~(m << st)) | ((d & m) << st);
  endtask

  function automatic logic [31:0] model_read(input logic [9:0] a, input logic [1:0] c);
    int e;
    e = eff(c);
    return (ref_mem[a[7:0]] >> estart(a, e)) & emask(e);
  endfunction

  // driver: one request cycle; write is applied to the model before the same-cycle read
  task automatic do_cycle(input bit we, input bit re, input logic [1:0] c,
                          input logic [9:0] aw, input logic [31:0] dw, input logic [9:0] ar,
                          input bit hand, input logic [31:0] hexp);
    bus.csb         = ~(we | re);
    bus.web         = ~we;
    bus.reb         = ~re;
    bus.conf        = c;
    bus.addr_w      = aw;
    bus.addr_r      = ar;
    bus.d_fabric_in = dw;
    if (rst) begin
      exp_q.delete();
      cyc_q.delete();
    end else begin
      if (we) model_write(aw, c, dw);
      if (re) begin
        exp_q.push_back(hand ? hexp : model_read(ar, c));
        cyc_q.push_back(cyc + 3 + int'(bus.out_reg));
      end
    end
    @(posedge clk);
    #1;
    bus.csb = 1'b1;
    bus.web = 1'b1;
    bus.reb = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (bus.d_fabric_out_valid === 1'b1) begin
      run++;
      if (run > max_run) max_run = run;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got data %h with nothing outstanding (cycle %0d)", bus.d_fabric_out, cyc);
      end else begin
        logic [31:0] e;
        int ec;
        e  = exp_q.pop_front();
        ec = cyc_q.pop_front();
        chk("rd_data", bus.d_fabric_out, e);
        chk("rd_latency", cyc, ec);
      end
    end else begin
      run = 0;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    rst             = 1'b1;
    bus.csb         = 1'b0;
    bus.web         = 1'b0;
    bus.reb         = 1'b0;
    bus.conf        = '0;
    bus.addr_w      = '0;
    bus.addr_r      = '0;
    bus.d_fabric_in = 32'hDEAD_BEEF;
    bus.out_reg     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_csb0", bus.csb0_sync, 1);
    chk("rst_csb1", bus.csb1_sync, 1);
    chk("rst_web0", bus.web0_sync, 1);
    chk("rst_wmask", bus.w_mask, 0);
    chk("rst_valid", bus.d_fabric_out_valid, 0);
    chk("rst_dout", bus.d_fabric_out, 0);
    bus.out_reg = 1'b1;
    #1;
    chk("rst_valid_oreg", bus.d_fabric_out_valid, 0);
    chk("rst_dout_oreg", bus.d_fabric_out, 0);
    bus.out_reg = 1'b0;
    rst     = 1'b0;
    bus.csb = 1'b1;
    bus.web = 1'b1;
    bus.reb = 1'b1;
    @(posedge clk);
    #1;

    // byte write
    do_cycle(1, 0, 2'd0, 10'h210, 32'h0000_00A5, 10'h000, 0, 0);
    chk("bw_wmask", bus.w_mask, 4'b0100);
    chk("bw_din", bus.d_sram_in, 32'hA5A5_A5A5);
    chk("bw_row", bus.baseaddr_w_sync, 8'h10);
    chk("bw_csb0", bus.csb0_sync, 0);
    chk("bw_csb1", bus.csb1_sync, 1);

    // preload rows used below
    do_cycle(1, 0, 2'd2, 10'h010, 32'h1234_5678, 10'h000, 0, 0);
    do_cycle(1, 0, 2'd2, 10'h020, 32'hFFFF_FFFF, 10'h000, 0, 0);
    do_cycle(1, 0, 2'd2, 10'h030, 32'h0BAD_F00D, 10'h000, 0, 0);
    do_cycle(1, 0, 2'd2, 10'h031, 32'hCAFE_BABE, 10'h000, 0, 0);

    // halfword read, direct then registered output
    do_cycle(0, 1, 2'd1, 10'h000, 32'h0, 10'h310, 1, 32'h0000_1234);
    drain();
    bus.out_reg = 1'b1;
    do_cycle(0, 1, 2'd1, 10'h000, 32'h0, 10'h310, 1, 32'h0000_1234);
    drain();
    bus.out_reg = 1'b0;

    // collisions
    do_cycle(1, 1, 2'd0, 10'h120, 32'h0000_0000, 10'h120, 1, 32'h0000_0000);
    do_cycle(0, 1, 2'd2, 10'h000, 32'h0, 10'h020, 1, 32'hFFFF_00FF);
    do_cycle(1, 1, 2'd0, 10'h220, 32'h0000_0011, 10'h320, 1, 32'h0000_00FF);
    do_cycle(1, 1, 2'd1, 10'h020, 32'h0000_BEEF, 10'h120, 1, 32'h0000_BEEF);
    chk("hw_din", bus.d_sram_in, 32'hBEEF_BEEF);
    chk("hw_wmask", bus.w_mask, 4'b0011);
    do_cycle(0, 1, 2'd3, 10'h000, 32'h0, 10'h220, 1, 32'hFF11_BEEF);
    drain();

    // csb high suppresses both ports
    bus.csb         = 1'b1;
    bus.web         = 1'b0;
    bus.reb         = 1'b0;
    bus.conf        = 2'd2;
    bus.addr_w      = 10'h030;
    bus.addr_r      = 10'h030;
    bus.d_fabric_in = 32'h0;
    @(posedge clk);
    #1;
    chk("csb_hi_csb0", bus.csb0_sync, 1);
    chk("csb_hi_csb1", bus.csb1_sync, 1);
    chk("csb_hi_wmask", bus.w_mask, 0);
    bus.web = 1'b1;
    bus.reb = 1'b1;
    do_cycle(0, 1, 2'd2, 10'h000, 32'h0, 10'h030, 1, 32'h0BAD_F00D);

    // simultaneous write and read on different rows
    do_cycle(1, 1, 2'd0, 10'h331, 32'h0000_0077, 10'h130, 1, 32'h0000_00F0);
    drain();

    // reset with reads in flight
    do_cycle(0, 1, 2'd2, 10'h000, 32'h0, 10'h031, 0, 0);
    rst = 1'b1;
    do_cycle(0, 1, 2'd2, 10'h000, 32'h0, 10'h031, 0, 0);
    do_cycle(0, 1, 2'd2, 10'h000, 32'h0, 10'h031, 0, 0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    do_cycle(0, 1, 2'd2, 10'h000, 32'h0, 10'h031, 1, 32'h77FE_BABE);
    drain();

    // back-to-back mixed stream
    max_run = 0;
    for (int i = 0; i < 16; i++) begin
      bit          we;
      logic [1:0]  c;
      logic [9:0]  aw, ar;
      we = 1'($urandom_range(0, 1));
      c  = 2'($urandom_range(0, 3));
      aw = {2'($urandom_range(0, 3)), 8'(32'h30 + $urandom_range(0, 1))};
      ar = {2'($urandom_range(0, 3)), 8'(32'h30 + $urandom_range(0, 1))};
      do_cycle(we, 1, c, aw, $urandom, ar, 0, 0);
    end
    drain();
    chk("stream_valid_run", max_run, 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sram_ifc_param.md
# sram_ifc_param

Parametrised fabric-to-SRAM interface for the dual-port (port 0 write, port 1 read) OpenRAM macro used in the FPGA fabric's block-RAM tile. It is the generalised successor of the fixed 8/32 interface:

- Word width, lane width and depth are parameters.
- Narrow-access mode runs over any power-of-two lane count.
- A read-valid pipeline is added.
- Same-cycle write/read collisions on one SRAM row are resolved by write-data forwarding.
- All control state is cleared by a synchronous reset.

## Interface
Parameters:
- DATA_W, 32, SRAM/fabric word width; must equal SUB_W × 2^k.
- SUB_W, 8, narrowest access width (lane width); NSUB = DATA_W/SUB_W lanes, SUBA_W = log2(NSUB).
- ADDR_W, 8, SRAM row address width; fabric address width is ADDR_W+SUBA_W.
- CONF_W, 2, width of conf; must satisfy 2^CONF_W > SUBA_W.

Ports:
- clk  in  1  single clock for all registers and the SRAM.
- rst  in  1  synchronous, active-high reset.
- d_fabric_in  in  DATA_W  write data; the element is in the low bits.
- csb  in  1  active-low chip select.
- web  in  1  active-low write request.
- reb  in  1  active-low read request.
- addr_w, addr_r  in  ADDR_W+SUBA_W  element address; the upper SUBA_W bits are the subaddress, the lower ADDR_W bits are the row.
- conf  in  CONF_W  element width = SUB_W<<conf; values above SUBA_W mean full word.
- out_reg  in  1  1 = add one registered output stage.
- d_sram_in  out  DATA_W  to SRAM din0.
- w_mask  out  NSUB  to SRAM wmask0; one bit per lane.
- d_sram_out  in  DATA_W  from SRAM dout1.
- csb0_sync, web0_sync, csb1_sync  out  1  to SRAM port controls.
- baseaddr_w_sync, baseaddr_r_sync  out  ADDR_W  to SRAM addr0/addr1.
- d_fabric_out  out  DATA_W  read element, zero-extended.
- d_fabric_out_valid  out  1  qualifies d_fabric_out.

## Operation
- **Stage 1 (capture):** registers d_fabric_in, both addresses, conf, csb0_sync = csb|web, web0_sync = web, csb1_sync = csb|reb, and rd_v = ~(csb|reb).
- **Lane selection:** e = min(conf, SUBA_W). Lane i is selected iff (i>>e) == (subaddr>>e); the low e bits of subaddr are ignored.
- **w_mask:** the selected lanes of subaddr_w_sync when a write is active (csb0_sync = 0), otherwise all-zero.
- **d_sram_in:** the low (SUB_W<<e) bits of the captured data, replicated across the word.
- **Collision:** coll = ~csb0_sync & ~csb1_sync & (baseaddr_w_sync == baseaddr_r_sync), evaluated in stage 1.
- **Stage 2:** pipes rd_v, conf, subaddr_r, coll, d_sram_in and w_mask.
- **Stage 3:**
  - Registers d_sram_out and the stage-2 side-band signals.
  - Merged word: lane i = stage-3 write data lane i if coll & w_mask[i], otherwise the SRAM lane. Write-before-read is the required semantics.
- **Output shifter:** selects the element at subaddr_r from the merged word, right-aligns it and zero-fills the upper bits. When e = SUBA_W, it passes the whole word.
- **out_reg = 0:** d_fabric_out and valid come straight from stage 3.
- **out_reg = 1:** they come from one further register.
- **Reset:**
  - csb0_sync, web0_sync and csb1_sync = 1.
  - All valid bits, coll, w_mask and data registers = 0.
  - d_fabric_out = 0 and d_fabric_out_valid = 0 in both out_reg modes.
  - Reset mid-operation discards every in-flight read; no valid is emitted for requests sampled before or during the reset cycle.
- **Simultaneous read and write to different rows:** independent, no interaction.
- **csb high:** suppresses both ports regardless of web/reb.

## Timing
- A request is sampled at edge N; SRAM port signals change after edge N. The SRAM samples them at N+1, dout1 settles before N+2, and stage 3 captures it at N+2.
- **out_reg = 0:** data and valid appear after edge N+2 (latency 2 after the sampling edge) and are held one cycle per request.
- **out_reg = 1:** they appear after edge N+3.
- **Throughput:** one read and one write per cycle, with no stalls.
- **Changing out_reg mid-stream:** permitted. Valid follows whichever path is selected, and a request may be seen twice or not at all.
- **Write visibility:** a write sampled at N is visible to a read sampled at N (through forwarding) or at N+1 or later (through the SRAM).

## Test plan
- **Reset:** hold rst 3 cycles with csb = 0, web = 0, reb = 0 → csb0_sync = csb1_sync = web0_sync = 1, w_mask = 0, d_fabric_out_valid = 0, d_fabric_out = 0.
- **Byte write:** DATA_W = 32, SUB_W = 8, conf = 0, write 0xA5 to addr_w = 0x2_10 → w_mask = 4'b0100, d_sram_in = 0xA5A5A5A5, baseaddr_w_sync = 0x10.
- **Halfword read:** row 0x10 holds 0x12345678, conf = 1, addr_r = 0x3_10 (subaddr 3, low bit ignored), out_reg = 0 → d_fabric_out = 0x00001234 with valid high for exactly one cycle, 2 cycles after the sampling edge. With out_reg = 1, the same result arrives 3 cycles after.
- **Collision:** row 0x20 holds 0xFFFFFFFF. Same-cycle write of 0x00 to byte 1 and full-word read (conf = 2) of row 0x20 → d_fabric_out = 0xFFFF00FF.
- **Reset mid-flight:** reads issued on 3 consecutive cycles, rst asserted on the 2nd → no valid for any of the three; a read issued after rst deasserts completes normally.
- **Back-to-back streaming:** 16 consecutive cycles of mixed reads and writes with random conf → every read result matches a reference memory model, in order, with valid never dropping.
